// File: rtl/mem_arbiter_mips32_if.sv
// mem_arbiter_mips32_if: fetch/data request ports plus the shared memory bus of the arbiter.
interface mem_arbiter_mips32_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter_mips32.sv
// mem_arbiter_mips32: single-port memory arbiter between MIPS fetch and data, with fetch anti-starvation.
module mem_arbiter_mips32 #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic                clk1,
    input logic                rst,
    mem_arbiter_mips32_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t        r_state;
    logic [SW-1:0] r_starve;
    logic [CW-1:0] r_wcnt;
    logic          r_owner_dm;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;

    logic w_idle;
    logic w_if_win;
    logic w_if_gnt;
    logic w_dm_gnt;

    // Data side wins unless fetch has been denied STARVE_MAX times in a row.
    assign w_idle   = (r_state == IDLE) && !rst;
    assign w_if_win = bus.if_req && (!bus.dm_req || r_starve == SW'(STARVE_MAX));
    assign w_if_gnt = w_idle && w_if_win;
    assign w_dm_gnt = w_idle && bus.dm_req && !w_if_win;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state    <= IDLE;
            r_starve   <= '0;
            r_wcnt     <= '0;
            r_owner_dm <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_starve <= (!bus.if_req || w_if_gnt) ? '0 :
                        (r_state == IDLE && r_starve != SW'(STARVE_MAX)) ? r_starve + SW'(1) : r_starve;
            case (r_state)
                IDLE: begin
                    if (w_if_gnt || w_dm_gnt) begin
                        r_state    <= ACCESS;
                        r_owner_dm <= w_dm_gnt;
                        r_we       <= w_dm_gnt && bus.dm_we;
                        r_addr     <= w_dm_gnt ? bus.dm_addr : bus.if_addr;
                        r_wdata    <= w_dm_gnt ? bus.dm_wdata : '0;
                    end
                end
                ACCESS: begin
                    r_state <= WAIT;
                    r_wcnt  <= '0;
                end
                WAIT: begin
                    if (r_wcnt == CW'(MEM_LAT - 1)) begin
                        r_state <= RESP;
                        if (!r_owner_dm)
                            r_if_rdata <= bus.mem_rdata;
                        else if (!r_we)
                            r_dm_rdata <= bus.mem_rdata;
                    end else begin
                        r_wcnt <= r_wcnt + CW'(1);
                    end
                end
                RESP: r_state <= IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.dm_gnt    = w_dm_gnt;
    assign bus.if_valid  = (r_state == RESP) && !r_owner_dm;
    assign bus.dm_valid  = (r_state == RESP) && r_owner_dm;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_en    = (r_state == ACCESS);
    assign bus.mem_we    = (r_state == ACCESS) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_mem_arbiter_mips32.sv
// tb_mem_arbiter_mips32: random fetch/load/store traffic with resets on MEM_LAT=1 and MEM_LAT=3 instances, checked against a cycle-timeline model.
module tb_mem_arbiter_mips32;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int NCYC = 3000;

    logic clk1 = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk1 = ~clk1;

    task automatic chk(input int lat, input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL L%0d %s: got %0h expected %0h", lat, tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] seed(input int a);
        return DW'(32'h9E3779B9 * (a + 7));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int L = g ? 3 : 1;

        logic          r = 1'b1;
        logic [DW-1:0] wmem [1<<AW];
        bit            wv   [1<<AW];
        logic [DW-1:0] pipe [L];

        mem_arbiter_mips32_if #(.AW(AW), .DW(DW)) b();
        mem_arbiter_mips32 #(.AW(AW), .DW(DW), .MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
            .clk1(clk1),
            .rst (r),
            .bus (b)
        );

        // Memory returns data MEM_LAT cycles after the strobe; junk otherwise.
        assign b.mem_rdata = pipe[L-1];
        always @(posedge clk1) begin
            if (b.mem_en && b.mem_we) begin
                wmem[b.mem_addr] <= b.mem_wdata;
                wv[b.mem_addr]   <= 1'b1;
            end
            pipe[0] <= b.mem_en ? (wv[b.mem_addr] ? wmem[b.mem_addr] : seed(int'(b.mem_addr))) : DW'($urandom);
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end

        initial begin : run
            logic [DW-1:0] mm [1<<AW];
            int            c, t_g, free_at, st;
            bit            known, own_dm, st_we, idle, win_if;
            bit            e_gif, e_gdm, e_en;
            logic [AW-1:0] m_addr;
            logic [DW-1:0] m_wd, if_rd, dm_rd, pend;
            for (int i = 0; i < (1 << AW); i++) mm[i] = seed(i);
            c = 0; t_g = -100; free_at = 0; st = 0; known = 0;
            own_dm = 0; st_we = 0; m_addr = '0; m_wd = '0; if_rd = '0; dm_rd = '0; pend = '0;
            b.if_req = 0; b.if_addr = '0;
            b.dm_req = 0; b.dm_we = 0; b.dm_addr = '0; b.dm_wdata = '0;
            for (int n = 0; n < NCYC; n++) begin
                @(negedge clk1);
                idle   = c >= free_at;
                win_if = b.if_req && (!b.dm_req || st == SMAX);
                e_gif  = known && idle && !r && win_if;
                e_gdm  = known && idle && !r && b.dm_req && !win_if;
                e_en   = c == t_g + 1;
                if (known) begin
                    chk(L, "busy", b.busy, !idle);
                    chk(L, "if_gnt", b.if_gnt, e_gif);
                    chk(L, "dm_gnt", b.dm_gnt, e_gdm);
                    chk(L, "mem_en", b.mem_en, e_en);
                    chk(L, "mem_we", b.mem_we, e_en && st_we);
                    chk(L, "if_valid", b.if_valid, c == t_g + 2 + L && !own_dm);
                    chk(L, "dm_valid", b.dm_valid, c == t_g + 2 + L && own_dm);
                    chk(L, "if_rdata", b.if_rdata, if_rd);
                    chk(L, "dm_rdata", b.dm_rdata, dm_rd);
                    if (e_en) chk(L, "mem_addr", b.mem_addr, m_addr);
                    if (e_en && st_we) chk(L, "mem_wdata", b.mem_wdata, m_wd);
                end
                if (r) begin
                    known = 1; free_at = c + 1; t_g = -100; st = 0; if_rd = '0; dm_rd = '0;
                end else begin
                    if (e_gif || e_gdm) begin
                        t_g     = c;
                        free_at = c + 3 + L;
                        own_dm  = e_gdm;
                        st_we   = e_gdm && b.dm_we;
                        m_addr  = e_gdm ? b.dm_addr : b.if_addr;
                        m_wd    = b.dm_wdata;
                        if (st_we) mm[m_addr] = m_wd;
                        else pend = mm[m_addr];
                    end
                    if (c + 1 == t_g + 2 + L && !st_we) begin
                        if (own_dm) dm_rd = pend;
                        else if_rd = pend;
                    end
                    st = (!b.if_req || e_gif) ? 0 : (idle && st < SMAX) ? st + 1 : st;
                end
                c++;
                @(posedge clk1);
                #1;
                if (e_gif) b.if_req = 0;
                if (e_gdm) b.dm_req = 0;
                if (!b.if_req && $urandom_range(0, 2) == 0) begin
                    b.if_req  = 1;
                    b.if_addr = AW'($urandom);
                end
                if (!b.dm_req && $urandom_range(0, 3) != 0) begin
                    b.dm_req   = 1;
                    b.dm_we    = 1'($urandom_range(0, 1));
                    b.dm_addr  = AW'($urandom_range(0, 15));
                    b.dm_wdata = DW'($urandom);
                end
                r = (n < 2) || ($urandom_range(0, 79) == 0);
            end
        end
    end

    initial begin
        repeat (NCYC + 10) @(posedge clk1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
